// File: rtl/riscv_run_monitor_pkg.sv
// Shared types and constants for the RISC-V run monitor: FSM state encoding,
// default pass/fail signatures and the trace entry width helper.
package riscv_run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_t;

    localparam logic [15:0] DEFAULT_PASS_VALUE = 16'h600D;
    localparam logic [15:0] DEFAULT_FAIL_VALUE = 16'hBAD0;

    // A trace entry is {cycle stamp, test value}.
    function automatic int trace_entry_width(input int cnt_w, input int tv_w);
        return cnt_w + tv_w;
    endfunction

endpackage

// File: rtl/run_trace_fifo.sv
// Synchronous FIFO for run trace entries with registered read data, occupancy
// count and a sticky overflow flag; a push into a full FIFO succeeds only alongside a pop.
module run_trace_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             r_overflow;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == LP_FULL);
    assign w_do_pop  = i_pop && !w_empty && !i_clear;
    // When full, the same-cycle pop frees the slot this push lands in.
    assign w_do_push = i_push && !i_clear && (!w_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rdata    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_rdata  <= r_mem[r_rd_ptr];
            end
            if (i_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata    = r_rdata;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/riscv_run_monitor.sv
// Run controller/observer for the pipelined RISC-V core: reset sequencing, run
// cycle count, pass/fail/timeout detection. Trace FIFO built only with RUN_MONITOR_TRACE_EN.
module riscv_run_monitor
    import riscv_run_monitor_pkg::*;
#(
    parameter int                    TV_WIDTH    = 16,
    parameter int                    CNT_WIDTH   = 16,
    parameter int                    RST_CYCLES  = 10,
    parameter int                    MAX_CYCLES  = 1100,
    parameter int                    TRACE_DEPTH = 16,
    parameter logic [TV_WIDTH-1:0]   PASS_VALUE  = DEFAULT_PASS_VALUE,
    parameter logic [TV_WIDTH-1:0]   FAIL_VALUE  = DEFAULT_FAIL_VALUE
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic                                    start,
    input  logic [TV_WIDTH-1:0]                     dut_test_value,
    output logic                                    dut_reset_n,
    output logic                                    running,
    output logic                                    done,
    output logic                                    pass,
    output logic                                    fail,
    output logic                                    timeout,
    output logic [CNT_WIDTH-1:0]                    cycle_count,
    input  logic                                    trace_rd_en,
    output logic [CNT_WIDTH+TV_WIDTH-1:0]           trace_rd_data,
    output logic                                    trace_empty,
    output logic [$clog2(TRACE_DEPTH):0]            trace_count,
    output logic                                    trace_overflow
);
    localparam int                   LP_TW       = trace_entry_width(CNT_WIDTH, TV_WIDTH);
    localparam int                   LP_HW       = $clog2(RST_CYCLES + 1);
    localparam logic [LP_HW-1:0]     LP_HOLD_END = LP_HW'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LP_RUN_END  = CNT_WIDTH'(MAX_CYCLES - 1);

    run_state_t           r_state;
    run_state_t           w_state_nxt;
    logic [LP_HW-1:0]     r_hold_cnt;
    logic [CNT_WIDTH-1:0] r_cycle_count;
    logic                 r_dut_reset_n;
    logic                 r_pass;
    logic                 r_fail;
    logic                 r_timeout;
    logic                 w_is_pass;
    logic                 w_is_fail;
    logic                 w_is_last;
    logic                 w_enter_hold;

    assign w_is_pass    = (dut_test_value == PASS_VALUE);
    assign w_is_fail    = (dut_test_value == FAIL_VALUE);
    assign w_is_last    = (r_cycle_count == LP_RUN_END);
    assign w_enter_hold = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_HOLD;
            ST_HOLD:          if (r_hold_cnt == LP_HOLD_END) w_state_nxt = ST_RUN;
            ST_RUN:           if (w_is_pass || w_is_fail || w_is_last) w_state_nxt = ST_DONE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_cycle_count <= '0;
            r_dut_reset_n <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            // Registered so the core's reset releases exactly as RUN begins.
            r_dut_reset_n <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE);
            if (w_enter_hold) begin
                r_hold_cnt    <= '0;
                r_cycle_count <= '0;
                r_pass        <= 1'b0;
                r_fail        <= 1'b0;
                r_timeout     <= 1'b0;
            end else if (r_state == ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt + LP_HW'(1);
            end else if (r_state == ST_RUN) begin
                // A signature on the last cycle takes precedence over timeout.
                if (w_is_pass) begin
                    r_pass <= 1'b1;
                end else if (w_is_fail) begin
                    r_fail <= 1'b1;
                end else if (w_is_last) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign dut_reset_n = r_dut_reset_n;
    assign running     = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

`ifdef RUN_MONITOR_TRACE_EN
    logic [TV_WIDTH-1:0] r_prev_value;
    logic                w_push;
    logic                w_unused_trace_full;

    // cycle_count is zero in RUN only on the first RUN cycle.
    assign w_push = (r_state == ST_RUN) &&
                    ((r_cycle_count == '0) || (dut_test_value != r_prev_value));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_prev_value <= '0;
        end else if (r_state == ST_RUN) begin
            r_prev_value <= dut_test_value;
        end
    end

    run_trace_fifo #(
        .WIDTH (LP_TW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_clear    (w_enter_hold),
        .i_push     (w_push),
        .i_wdata    ({r_cycle_count, dut_test_value}),
        .i_pop      (trace_rd_en),
        .o_rdata    (trace_rd_data),
        .o_empty    (trace_empty),
        .o_full     (w_unused_trace_full),
        .o_count    (trace_count),
        .o_overflow (trace_overflow)
    );
`else
    logic w_unused_trace_rd_en;

    assign w_unused_trace_rd_en = trace_rd_en;
    assign trace_rd_data        = '0;
    assign trace_empty          = 1'b1;
    assign trace_count          = '0;
    assign trace_overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Directed-plus-random bench for riscv_run_monitor with a queue-based reference
// model of run outcome and trace contents; works with or without RUN_MONITOR_TRACE_EN.
module tb_riscv_run_monitor;
    localparam int          RSTC   = 10;
    localparam int          MAXC   = 1100;
    localparam int          DEPTH  = 16;
    localparam logic [15:0] PASS_V = 16'h600D;
    localparam logic [15:0] FAIL_V = 16'hBAD0;
`ifdef RUN_MONITOR_TRACE_EN
    localparam bit TRACE_EN = 1'b1;
`else
    localparam bit TRACE_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [15:0] dut_test_value;
    logic        dut_reset_n;
    logic        running;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] cycle_count;
    logic        trace_rd_en;
    logic [31:0] trace_rd_data;
    logic        trace_empty;
    logic [4:0]  trace_count;
    logic        trace_overflow;

    riscv_run_monitor #(
        .TV_WIDTH    (16),
        .CNT_WIDTH   (16),
        .RST_CYCLES  (RSTC),
        .MAX_CYCLES  (MAXC),
        .TRACE_DEPTH (DEPTH),
        .PASS_VALUE  (PASS_V),
        .FAIL_VALUE  (FAIL_V)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .start          (start),
        .dut_test_value (dut_test_value),
        .dut_reset_n    (dut_reset_n),
        .running        (running),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .timeout        (timeout),
        .cycle_count    (cycle_count),
        .trace_rd_en    (trace_rd_en),
        .trace_rd_data  (trace_rd_data),
        .trace_empty    (trace_empty),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] stim [MAXC];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd = '0;

    int          m_end;
    bit          m_pass;
    bit          m_fail;
    bit          m_tmo;
    bit          m_ovf;
    logic [31:0] m_pop_data;
    int          m_cnt_at_pop;
    bit          m_ovf_at_pop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        v = 16'($urandom_range(0, 65535));
        while (v == PASS_V || v == FAIL_V) v = 16'($urandom_range(0, 65535));
        return v;
    endfunction

    task automatic fill_fast();
        for (int i = 0; i < MAXC; i++) stim[i] = 16'($urandom_range(0, 7));
    endtask

    task automatic fill_slow();
        logic [15:0] v;
        v = rand_val();
        for (int i = 0; i < MAXC; i++) begin
            if ($urandom_range(0, 99) < 3) v = rand_val();
            stim[i] = v;
        end
    endtask

    // Walk the stimulus cycle by cycle: outcome, end cycle and trace queue contents.
    task automatic build_model(input int pop_at);
        logic [15:0] v;
        logic [15:0] prev;
        exp_q.delete();
        m_ovf = 0; m_pass = 0; m_fail = 0; m_tmo = 0; m_end = -1;
        m_pop_data = last_rd; m_cnt_at_pop = 0; m_ovf_at_pop = 0;
        prev = '0;
        for (int i = 0; i < MAXC; i++) begin
            v = stim[i];
            if (i == pop_at && exp_q.size() > 0) m_pop_data = exp_q.pop_front();
            if (TRACE_EN && (i == 0 || v != prev)) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({16'(i), v});
                else m_ovf = 1;
            end
            if (i == pop_at) begin
                m_cnt_at_pop = exp_q.size();
                m_ovf_at_pop = m_ovf;
            end
            prev = v;
            if (v == PASS_V || v == FAIL_V || i == MAXC - 1) begin
                m_end  = i;
                m_pass = (v == PASS_V);
                m_fail = (v == FAIL_V);
                m_tmo  = !m_pass && !m_fail;
                break;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "/reset_n"}, dut_reset_n, 1'b0);
        chk({tag, "/run_done"}, {running, done}, 2'b00);
        chk({tag, "/flags"}, {pass, fail, timeout, trace_overflow}, 4'b0000);
        chk({tag, "/cycle_count"}, cycle_count, 16'd0);
        chk({tag, "/trace_count"}, trace_count, 5'd0);
        chk({tag, "/trace_empty"}, trace_empty, 1'b1);
    endtask

    task automatic do_run(input string tag, input int pop_at, input int reset_at, input bit poke_start);
        int          hold;
        int          k;
        bit          fin;
        bit          hold_ok;
        bit          run_ok;
        logic [31:0] e;
        build_model(pop_at);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk({tag, "/clr_flags"}, {pass, fail, timeout, trace_overflow}, 4'b0000);
        chk({tag, "/clr_count"}, {cycle_count, 11'(trace_count), trace_empty}, {16'd0, 11'd0, 1'b1});
        hold = 0;
        hold_ok = 1;
        while (!running && hold < 50) begin
            if (dut_reset_n !== 1'b0 || done !== 1'b0) hold_ok = 0;
            hold++;
            start = poke_start && (hold == 3);
            @(posedge CLK); #1;
        end
        start = 1'b0;
        chk({tag, "/hold_cycles"}, hold, RSTC);
        chk({tag, "/hold_reset_low"}, hold_ok, 1'b1);
        chk({tag, "/reset_n_rise"}, dut_reset_n, 1'b1);

        k = 0;
        fin = 0;
        run_ok = 1;
        dut_test_value = stim[0];
        trace_rd_en = (pop_at == 0);
        while (!fin && k < MAXC + 10) begin
            @(posedge CLK); #1;
            trace_rd_en = 1'b0;
            start = 1'b0;
            if (k == pop_at) begin
                chk({tag, "/mid_pop_data"}, trace_rd_data, m_pop_data);
                chk({tag, "/mid_pop_count"}, trace_count, m_cnt_at_pop);
                chk({tag, "/mid_pop_ovf"}, trace_overflow, m_ovf_at_pop);
                last_rd = m_pop_data;
            end
            if (done) begin
                fin = 1;
            end else begin
                if (running !== 1'b1 || dut_reset_n !== 1'b1) run_ok = 0;
                k++;
                if (k == reset_at) begin
                    RESET = 1'b1;
                    @(posedge CLK); #1;
                    RESET = 1'b0;
                    last_rd = '0;
                    check_idle({tag, "/midreset"});
                    return;
                end
                dut_test_value = stim[k];
                trace_rd_en = (k == pop_at);
                start = poke_start && (k == 5);
            end
        end
        chk({tag, "/done_seen"}, fin, 1'b1);
        chk({tag, "/running_during_run"}, run_ok, 1'b1);
        chk({tag, "/end_cycle"}, k, m_end);
        chk({tag, "/cycle_count"}, cycle_count, 16'(m_end));
        chk({tag, "/pass_fail_tmo"}, {pass, fail, timeout}, {m_pass, m_fail, m_tmo});
        chk({tag, "/state_out"}, {running, dut_reset_n}, 2'b01);
        chk({tag, "/trace_count"}, trace_count, exp_q.size());
        chk({tag, "/trace_overflow"}, trace_overflow, m_ovf);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            trace_rd_en = 1'b1;
            @(posedge CLK); #1;
            trace_rd_en = 1'b0;
            chk({tag, "/drain_entry"}, trace_rd_data, e);
            last_rd = e;
        end
        chk({tag, "/drained_empty"}, {trace_empty, trace_count}, {1'b1, 5'd0});
        trace_rd_en = 1'b1;
        @(posedge CLK); #1;
        trace_rd_en = 1'b0;
        chk({tag, "/empty_pop_hold"}, trace_rd_data, last_rd);
        chk({tag, "/done_frozen"}, {done, cycle_count}, {1'b1, 16'(m_end)});
    endtask

    initial begin
        int endc;
        int p;
        RESET = 1'b1;
        start = 1'b0;
        trace_rd_en = 1'b0;
        dut_test_value = 16'h0001;
        repeat (3) @(posedge CLK);
        #1;
        check_idle("reset");
        chk("reset/rd_data", trace_rd_data, 32'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < MAXC; i++) stim[i] = 16'h0001;
        do_run("timeout", -1, -1, 1'b1);

        fill_fast();
        stim[37] = PASS_V;
        do_run("pass37", -1, -1, 1'b0);

        fill_slow();
        stim[MAXC-1] = FAIL_V;
        do_run("fail_last", -1, -1, 1'b0);

        for (int i = 0; i < MAXC; i++) stim[i] = (i < 20) ? 16'h0100 + 16'(i) : 16'h0200;
        stim[30] = PASS_V;
        do_run("overflow", -1, -1, 1'b0);

        for (int i = 0; i < MAXC; i++) stim[i] = (i < 16) ? 16'h0300 + 16'(i) : 16'h03FF;
        stim[22] = PASS_V;
        do_run("full_pushpop", 16, -1, 1'b0);

        fill_slow();
        do_run("midreset", -1, 500, 1'b0);

        for (int r = 0; r < 4; r++) begin
            endc = $urandom_range(1, 300);
            fill_fast();
            stim[endc] = ($urandom_range(0, 1) == 1) ? PASS_V : FAIL_V;
            p = $urandom_range(0, endc);
            do_run("random", p, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
